// File: rtl/alu_control_unit_if.sv
// ROM fetch handshake and ALU/datapath control bundle for the nibble processor control unit.
// The master modport is the control unit; the slave modport is the ROM/ALU/datapath side.
interface alu_control_unit_if;
    logic       fetch_req;
    logic       rom_valid;
    logic [3:0] opcode;
    logic       alu_c;
    logic       alu_z;
    logic [2:0] alu_f;
    logic [1:0] bus_src;
    logic       acc_we;
    logic       mem_we;
    logic       out_we;
    logic       pc_inc;
    logic       pc_load;

    modport master (
        output fetch_req, alu_f, bus_src, acc_we, mem_we, out_we, pc_inc, pc_load,
        input  rom_valid, opcode, alu_c, alu_z
    );

    modport slave (
        input  fetch_req, alu_f, bus_src, acc_we, mem_we, out_we, pc_inc, pc_load,
        output rom_valid, opcode, alu_c, alu_z
    );
endinterface

// File: rtl/alu_control_unit.sv
// FETCH/EXEC control unit for the 4-bit nibble processor, with registered C/Z flags.
// Define ALU_CTRL_HALT_EN to give opcode F a HALT state left via resume; otherwise F is a NOP.
module alu_control_unit #(
    parameter int FETCH_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_control_unit_if.master  bus,
    output logic                flag_c,
    output logic                flag_z,
    output logic                phase,
    output logic                halted,
    input  logic                resume,
    output logic                fetch_err,
    input  logic                err_clr
);

`ifdef ALU_CTRL_HALT_EN
    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;
`else
    typedef enum logic {S_FETCH, S_EXEC} state_t;
`endif

    localparam logic [7:0] TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);

    state_t     state, next_state;
    logic [3:0] op_reg;
    logic [7:0] tcnt;
    logic       flag_wr;
    logic       jump, taken, halt_entry;
    logic       timeout_hit;
    logic       fetch_req, acc_we, mem_we, out_we, pc_inc, pc_load;
    logic [2:0] alu_f;
    logic [1:0] bus_src;

`ifndef ALU_CTRL_HALT_EN
    logic resume_unused;
    assign resume_unused = resume;
`endif

    assign timeout_hit = (state == S_FETCH) && !bus.rom_valid && (tcnt == TIMEOUT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            op_reg    <= 4'h0;
            flag_c    <= 1'b0;
            flag_z    <= 1'b0;
            fetch_err <= 1'b0;
            tcnt      <= 8'd0;
        end else begin
            state <= next_state;
            if (state == S_FETCH) begin
                if (bus.rom_valid) begin
                    op_reg <= bus.opcode;
                    tcnt   <= 8'd0;
                end else if (timeout_hit) begin
                    tcnt   <= 8'd0;
                end else begin
                    tcnt   <= tcnt + 8'd1;
                end
            end
            if (flag_wr) begin
                flag_c <= bus.alu_c;
                flag_z <= bus.alu_z;
            end
            // A timeout in the same cycle as err_clr keeps the error visible.
            if (timeout_hit)
                fetch_err <= 1'b1;
            else if (err_clr)
                fetch_err <= 1'b0;
        end
    end

    always_comb begin
        next_state = state;
        fetch_req  = 1'b0;
        alu_f      = 3'b000;
        bus_src    = 2'b00;
        acc_we     = 1'b0;
        mem_we     = 1'b0;
        out_we     = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        phase      = 1'b0;
        halted     = 1'b0;
        flag_wr    = 1'b0;
        jump       = 1'b0;
        taken      = 1'b0;
        halt_entry = 1'b0;
        case (state)
            S_FETCH: begin
                fetch_req = 1'b1;
                if (bus.rom_valid)
                    next_state = S_EXEC;
            end
            S_EXEC: begin
                phase      = 1'b1;
                next_state = S_FETCH;
                case (op_reg)
                    4'h1: begin jump = 1'b1; taken = flag_c;  end
                    4'h2: begin jump = 1'b1; taken = !flag_c; end
                    4'h9: begin jump = 1'b1; taken = flag_z;  end
                    4'hC: begin jump = 1'b1; taken = !flag_z; end
                    4'h3: begin alu_f = 3'b001; bus_src = 2'b01; flag_wr = 1'b1; end
                    4'h4: begin alu_f = 3'b001; bus_src = 2'b10; flag_wr = 1'b1; end
                    4'h5: begin alu_f = 3'b010; bus_src = 2'b01; acc_we = 1'b1; flag_wr = 1'b1; end
                    4'h6: begin alu_f = 3'b010; bus_src = 2'b11; acc_we = 1'b1; flag_wr = 1'b1; end
                    4'h7: begin alu_f = 3'b010; bus_src = 2'b10; acc_we = 1'b1; flag_wr = 1'b1; end
                    4'h8: mem_we = 1'b1;
                    4'hA: begin alu_f = 3'b011; bus_src = 2'b01; acc_we = 1'b1; flag_wr = 1'b1; end
                    4'hB: begin alu_f = 3'b011; bus_src = 2'b10; acc_we = 1'b1; flag_wr = 1'b1; end
                    4'hD: begin alu_f = 3'b100; bus_src = 2'b01; acc_we = 1'b1; flag_wr = 1'b1; end
                    4'hE: out_we = 1'b1;
`ifdef ALU_CTRL_HALT_EN
                    4'hF: begin halt_entry = 1'b1; next_state = S_HALT; end
`endif
                    default: ;
                endcase
                pc_load = jump && taken;
                pc_inc  = !(jump && taken) && !halt_entry;
            end
`ifdef ALU_CTRL_HALT_EN
            S_HALT: begin
                phase  = 1'b1;
                halted = 1'b1;
                if (resume) begin
                    pc_inc     = 1'b1;
                    next_state = S_FETCH;
                end
            end
`endif
            default: next_state = S_FETCH;
        endcase
    end

    assign bus.fetch_req = fetch_req;
    assign bus.alu_f     = alu_f;
    assign bus.bus_src   = bus_src;
    assign bus.acc_we    = acc_we;
    assign bus.mem_we    = mem_we;
    assign bus.out_we    = out_we;
    assign bus.pc_inc    = pc_inc;
    assign bus.pc_load   = pc_load;

endmodule
